// File: rtl/riscv_test_monitor_if.sv
// rtl/riscv_test_monitor_if.sv - core-side sample inputs and verdict outputs of the riscv-tests monitor
interface riscv_test_monitor_if;
    logic        start;
    logic [31:0] pc;
    logic [31:0] gp;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        hang;
    logic [30:0] fail_testnum;
    logic [31:0] cycles;

    // Core/bench side: drives the arm pulse and the sampled core state.
    modport master (
        output start, pc, gp,
        input  busy, done, pass, fail, timeout, hang, fail_testnum, cycles
    );

    // Monitor side: samples core state and publishes the sticky verdict.
    modport slave (
        input  start, pc, gp,
        output busy, done, pass, fail, timeout, hang, fail_testnum, cycles
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - sticky pass/fail/timeout/hang verdict from fetch pc and x3
module riscv_test_monitor #(
    parameter logic [31:0] PASS_PC     = 32'h44,
    parameter int unsigned TIMEOUT     = 5000,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_test_monitor_if.slave  mon
);

    // Last RUN cycle index that still fits inside the budget, and the stall
    // count at which one more repeated pc completes a hang.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] STALL_LAST   = 32'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] cycles_q;
    logic [31:0] stall_q;
    logic [31:0] pc_prev_q;
    logic        pass_q;
    logic        fail_q;
    logic        timeout_q;
    logic        hang_q;
    logic [30:0] fail_testnum_q;

    logic        arm;
    logic        pc_same;
    logic        hit_pass;
    logic        hit_fail;
    logic        hit_timeout;
    logic        hit_hang;

    assign pc_same = (mon.pc == pc_prev_q);

    // State register; reset drops straight back to IDLE regardless of the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus verdict decode; the pass landing point outranks timeout,
    // and timeout outranks hang, so exactly one flag fires per run.
    always_comb begin
        state_next  = state;
        arm         = 1'b0;
        hit_pass    = 1'b0;
        hit_fail    = 1'b0;
        hit_timeout = 1'b0;
        hit_hang    = 1'b0;
        case (state)
            IDLE: begin
                if (mon.start) begin
                    arm        = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mon.pc == PASS_PC) begin
                    if (mon.gp == 32'h1) begin
                        hit_pass = 1'b1;
                    end else begin
                        hit_fail = 1'b1;
                    end
                end else if (cycles_q == TIMEOUT_LAST) begin
                    hit_timeout = 1'b1;
                end else if ((stall_q == STALL_LAST) && pc_same) begin
                    hit_hang = 1'b1;
                end
                if (hit_pass || hit_fail || hit_timeout || hit_hang) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (mon.start) begin
                    arm        = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run counters and verdict registers; the arm edge seeds pc_prev so the
    // first RUN cycle compares against the pc seen while arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q       <= '0;
            stall_q        <= '0;
            pc_prev_q      <= '0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
            hang_q         <= 1'b0;
            fail_testnum_q <= '0;
        end else if (arm) begin
            cycles_q       <= '0;
            stall_q        <= '0;
            pc_prev_q      <= mon.pc;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
            hang_q         <= 1'b0;
            fail_testnum_q <= '0;
        end else if (state == RUN) begin
            cycles_q  <= (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
            if (pc_same) begin
                stall_q <= (stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1;
            end else begin
                stall_q <= '0;
            end
            pc_prev_q <= mon.pc;
            pass_q    <= hit_pass;
            fail_q    <= hit_fail;
            timeout_q <= hit_timeout;
            hang_q    <= hit_hang;
            if (hit_fail) begin
                fail_testnum_q <= mon.gp[31:1];
            end
        end
    end

    assign mon.busy         = (state == RUN);
    assign mon.done         = (state == DONE);
    assign mon.pass         = pass_q;
    assign mon.fail         = fail_q;
    assign mon.timeout      = timeout_q;
    assign mon.hang         = hang_q;
    assign mon.fail_testnum = fail_testnum_q;
    assign mon.cycles       = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - randomized model-checked bench for riscv_test_monitor
module tb_riscv_test_monitor;

    localparam logic [31:0] PASS_PC     = 32'h44;
    localparam int          TIMEOUT     = 100;
    localparam int          STALL_LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    riscv_test_monitor_if bus ();

    riscv_test_monitor #(
        .PASS_PC     (PASS_PC),
        .TIMEOUT     (TIMEOUT),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .mon (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference model: mode 0 idle, 1 running, 2 verdict held.
    int          m_mode    = 0;
    logic [31:0] m_cycles  = '0;
    logic        m_pass    = 1'b0;
    logic        m_fail    = 1'b0;
    logic        m_timeout = 1'b0;
    logic        m_hang    = 1'b0;
    logic [30:0] m_testnum = '0;
    logic [31:0] hist[$];
    int          m_same;
    bit          m_stop;
    bit          m_verdict;

    // A hang is the current pc plus the STALL_LIMIT pcs before it (the arm-time
    // pc included) all being identical.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cycles = '0; m_testnum = '0;
            m_pass = 0; m_fail = 0; m_timeout = 0; m_hang = 0;
            hist.delete();
        end else if (m_mode != 1 && bus.start) begin
            m_mode = 1; m_cycles = '0; m_testnum = '0;
            m_pass = 0; m_fail = 0; m_timeout = 0; m_hang = 0;
            hist.delete();
            hist.push_back(bus.pc);
        end else if (m_mode == 1) begin
            hist.push_back(bus.pc);
            if (hist.size() > STALL_LIMIT + 1) void'(hist.pop_front());
            m_same = 0;
            m_stop = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (!m_stop && hist[i] == bus.pc) m_same++;
                else m_stop = 1;
            end
            m_verdict = 1;
            if (bus.pc == PASS_PC) begin
                if (bus.gp == 32'h1) m_pass = 1;
                else begin
                    m_fail    = 1;
                    m_testnum = bus.gp[31:1];
                end
            end else if (m_cycles == TIMEOUT - 1) begin
                m_timeout = 1;
            end else if (m_same >= STALL_LIMIT + 1) begin
                m_hang = 1;
            end else begin
                m_verdict = 0;
            end
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            if (m_verdict) m_mode = 2;
        end
    end

    logic [68:0] act_vec;
    logic [68:0] exp_vec;
    assign act_vec = {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.hang,
                      bus.fail_testnum, bus.cycles};
    assign exp_vec = {(m_mode == 1), (m_mode == 2), m_pass, m_fail, m_timeout, m_hang,
                      m_testnum, m_cycles};

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t dut=%h model=%h", $time, act_vec, exp_vec);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] p, input logic [31:0] g);
        @(negedge clk);
        #1;
        bus.start = s;
        bus.pc    = p;
        bus.gp    = g;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic run_s1(input string tag);
        drive(1, 32'h0, 32'h0);
        for (int i = 0; i <= 16; i++) drive(0, 32'(4 * i), 32'h0);
        drive(0, PASS_PC, 32'h1);
        settle();
        check({tag, "_done"},   bus.done,   1);
        check({tag, "_pass"},   bus.pass,   1);
        check({tag, "_busy"},   bus.busy,   0);
        check({tag, "_cycles"}, bus.cycles, 32'd18);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int style;
        int r;
        logic [31:0] p;
        logic [31:0] g;
        logic        s;

        bus.start = 0;
        bus.pc    = 0;
        bus.gp    = 0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        checking = 1;
        #2;
        check("reset_busy",   bus.busy,   0);
        check("reset_done",   bus.done,   0);
        check("reset_cycles", bus.cycles, 0);
        check("reset_flags",  {bus.pass, bus.fail, bus.timeout, bus.hang}, 0);
        @(negedge clk);
        #1 rst_n = 1;

        // Normal pass after walking up to the landing point.
        run_s1("s1");

        // Fail, armed while pc already sits on the landing point.
        drive(1, PASS_PC, 32'h0000_000B);
        drive(0, PASS_PC, 32'h0000_000B);
        settle();
        check("s2_fail",     bus.fail,         1);
        check("s2_testnum",  bus.fail_testnum, 5);
        check("s2_pass",     bus.pass,         0);
        check("s2_timeout",  bus.timeout,      0);
        check("s2_cycles",   bus.cycles,       1);

        // Timeout with a pc that never repeats.
        drive(1, 32'h1000, 32'h0);
        for (int i = 1; i <= 100; i++) drive(0, 32'h1000 + 32'(4 * i), 32'h0);
        settle();
        check("s3_timeout", bus.timeout, 1);
        check("s3_cycles",  bus.cycles,  32'd100);
        check("s3_busy",    bus.busy,    0);

        // Hang on a frozen pc, then a frozen pc on the landing point passes.
        drive(1, 32'h20, 32'h0);
        for (int i = 0; i < 8; i++) drive(0, 32'h20, 32'h0);
        settle();
        check("s4_hang",   bus.hang,   1);
        check("s4_cycles", bus.cycles, 32'd8);
        drive(1, PASS_PC, 32'h1);
        for (int i = 0; i < 8; i++) drive(0, PASS_PC, 32'h1);
        settle();
        check("s4b_pass", bus.pass, 1);
        check("s4b_hang", bus.hang, 0);

        // Landing point on the very last budget cycle wins over timeout.
        drive(1, 32'h1000, 32'h0);
        for (int i = 1; i <= 99; i++) drive(0, 32'h1000 + 32'(4 * i), 32'h0);
        drive(0, PASS_PC, 32'h1);
        settle();
        check("s5_pass",    bus.pass,    1);
        check("s5_timeout", bus.timeout, 0);
        check("s5_cycles",  bus.cycles,  32'd100);

        // Reset between edges mid-run, then an identical rerun.
        drive(1, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) drive(0, 32'(4 * i), 32'h0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("s6_busy",   bus.busy,   0);
        check("s6_done",   bus.done,   0);
        check("s6_cycles", bus.cycles, 0);
        check("s6_flags",  {bus.pass, bus.fail, bus.timeout, bus.hang, bus.fail_testnum}, 0);
        @(negedge clk);
        #1 rst_n = 1;
        run_s1("s6_rerun");

        // Randomized runs.
        for (int run = 0; run < 40; run++) begin
            style = $urandom_range(0, 2);
            p     = 32'($urandom_range(0, 255)) << 2;
            drive(1, p, $urandom);
            n = 0;
            do begin
                r = $urandom_range(0, 99);
                if (r < 4) p = PASS_PC;
                else if (style == 0 && r < 92) p = p;
                else if (style == 2 && r < 50) p = p;
                else if (style == 1 || r >= 50) p = 32'($urandom_range(64, 1023)) << 2;
                g = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
                s = ($urandom_range(0, 99) < 3);
                drive(s, p, g);
                if (run % 7 == 3 && n == 10) begin
                    @(posedge clk);
                    #3 rst_n = 0;
                    @(negedge clk);
                    #1 rst_n = 1;
                end
                n++;
            end while (m_mode == 1 && n < 400);
            if (m_mode == 1) begin
                vectors++;
                miscompares++;
                $display("FAIL run_bound: run %0d still busy after %0d cycles", run, n);
            end
            for (int k = 0; k < 3; k++) drive(0, $urandom, $urandom);
        end

        settle();
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
